tpg_session_ctrl: RTL
=====================

// Module: tpg_session_ctrl
// PURPOSE
//  Sequences one test-pattern session on an embedded 8-bit bit-swapping LFSR.
//  On start it loads a seed, then emits exactly num_pat patterns over a valid/ready stream.
//  The LFSR advances only on accepted beats. Optional bit-swap output mode.
//  Sits between the test-session sequencer and the pattern consumer (scan/BIST load).
// PARAMETERS
//  CNT_W   16   width of pattern-count request and accepted-count output
// PORTS
//  clk       in   1      clock, all state on posedge
//  set       in   1      reset, asynchronous, active-high
//  start     in   1      session start pulse; honoured only in IDLE or DONE
//  seed      in   8      LFSR seed, sampled with start; 8'h00 replaced by 8'hFF
//  num_pat   in   CNT_W  patterns to emit, sampled with start
//  bs_en     in   1      bit-swap output enable, sampled with start
//  abort     in   1      terminate session, honoured in RUN
//  pat_valid out  1      pattern available
//  pat_ready in   1      consumer accepts when pat_valid & pat_ready
//  pat_data  out  8      pattern; stable while pat_valid & ~pat_ready
//  busy      out  1      1 in RUN
//  done      out  1      sticky 1 in DONE; cleared by next start or reset
//  pat_cnt   out  CNT_W  accepted beats this session; held after DONE/abort
// BEHAVIOUR
//  Reset (async, set=1): state=IDLE, s=8'hFF, pat_cnt=0, pat_valid=0, busy=0, done=0,
//   bs latch=0, so pat_data=8'hFF.
//  LFSR state s[7:0]: next(s) = {s[7]^s[0], s[7:1]}.
//  Output map: if bs_q & ~s[0]: pat_data = {s[6],s[7],s[4],s[5],s[2],s[3],s[1],s[0]};
//   otherwise pat_data = s. pat_data is combinational from registered s and bs_q.
//  FSM states: IDLE, RUN, DONE.
//   IDLE/DONE + start:
//    s <= (seed==0) ? 8'hFF : seed; n_q <= num_pat; bs_q <= bs_en; pat_cnt <= 0; done <= 0.
//    n_q==0 (num_pat==0) -> DONE next cycle, done=1, no pat_valid.
//    Otherwise -> RUN next cycle.
//   RUN: pat_valid=1, busy=1. On accept: pat_cnt++, s <= next(s).
//    If pat_cnt+1 == n_q, go to DONE next cycle.
//   DONE: done=1, busy=0, pat_valid=0. Holds until start.
//  Latency: start at edge t -> first pattern (the seed, mapped) valid after edge t.
//   Throughput is 1 pattern/cycle when pat_ready is held high.
//  Handshake: once pat_valid rises it stays high until accepted or abort.
//   pat_data and s do not change while pat_valid & ~pat_ready.
//  abort in RUN: takes priority over a same-cycle accept.
//   The beat is not counted and s is not advanced. Next state is IDLE, done stays 0.
//   abort in IDLE/DONE is ignored. start in RUN is ignored.
//  start & abort in the same IDLE cycle: start wins.
//  pat_cnt compares against n_q at full CNT_W width; no wrap, since the count stops at n_q.
//  Reset mid-session: immediate return to reset values, no completion signalled.
// TESTING
//  1 seed=01, bs_en=0, num_pat=3, ready=1 -> pat_data 01, 80, C0 on consecutive cycles;
//    done=1 the cycle after the 3rd beat; pat_cnt=3.
//  2 As 1 with bs_en=1 -> pat_data 01, 40, C0; done after the 3rd beat.
//  3 seed=01, num_pat=2, ready low 3 cycles after valid -> pat_data holds 01 with valid=1;
//    then 01 and 80 accepted; pat_cnt=2.
//  4 seed=00, num_pat=1 -> single beat pat_data=FF, done=1.
//    Repeat with num_pat=0 -> done=1 one cycle after start, pat_valid never high.
//  5 num_pat=10, ready=1, abort with ready on the 4th beat -> pat_cnt=3, state IDLE, done=0.
//    Then start seed=01 -> session runs normally from 01.
//  6 Assert set during RUN -> outputs return to reset values asynchronously.
//    start in RUN ignored: pat_cnt and s are unaffected.

Source files
------------

// File: rtl/tpg_session_ctrl.sv
// Test-pattern session controller.
// Loads a seed into an 8-bit bit-swapping LFSR, then emits num_pat patterns
// over a valid/ready stream. The LFSR advances only on accepted beats.
module tpg_session_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             set,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic             bs_en,
  input  logic             abort,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [7:0]       pat_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       s_q;
  logic [CNT_W-1:0] n_q;
  logic             bs_q;
  logic             load;
  logic             adv;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       s_next;

  assign cnt_inc = pat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign s_next  = {s_q[7] ^ s_q[0], s_q[7:1]};

  // State register
  always_ff @(posedge clk or posedge set) begin
    if (set) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and datapath enables; abort outranks a same-cycle accept
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (num_pat == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pat_ready) begin
          adv = 1'b1;
          if (cnt_inc == n_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session datapath: seed load, LFSR step and accepted-beat counter
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      s_q     <= '1;
      n_q     <= '0;
      bs_q    <= 1'b0;
      pat_cnt <= '0;
    end else if (load) begin
      s_q     <= (seed == 8'h00) ? 8'hFF : seed;
      n_q     <= num_pat;
      bs_q    <= bs_en;
      pat_cnt <= '0;
    end else if (adv) begin
      s_q     <= s_next;
      pat_cnt <= cnt_inc;
    end
  end

  // Output mapping: pairwise swap of the upper six bits when enabled and s[0]=0
  always_comb begin
    if (bs_q && !s_q[0])
      pat_data = {s_q[6], s_q[7], s_q[4], s_q[5], s_q[2], s_q[3], s_q[1], s_q[0]};
    else
      pat_data = s_q;
  end

  assign pat_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule
